// File: rtl/program_loader.sv
// Instruction-store loader: accepts a valid/ready word stream and writes it to
// consecutive addresses from 0, holding the CPU and accumulating a checksum.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [7:0]        checksum
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [CNT_W-1:0]    len_reg, len_next;
    logic [7:0]          sum_reg, sum_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                accept;

    assign in_ready  = (state_reg == LOAD) && (count_reg < len_reg);
    assign accept    = in_ready && in_valid;
    assign busy      = (state_reg == LOAD);
    assign cpu_hold  = busy;
    assign done      = (state_reg == DONE);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign checksum  = sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            len_reg   <= '0;
            sum_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            sum_reg   <= sum_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        len_next   = len_reg;
        sum_next   = sum_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    count_next = '0;
                    sum_next   = '0;
                    if (length == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                        // Oversized requests clamp so the address never wraps.
                        len_next   = (length > DEPTH_C) ? DEPTH_C : length;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    we_next    = 1'b1;
                    addr_next  = count_reg[ADDR_W-1:0];
                    wdata_next = in_data;
                    count_next = count_reg + CNT_W'(1);
                    sum_next   = sum_reg + 8'(in_data);
                    if (count_next == len_reg) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven loads, randomized loads against a
// queue-free word-count/sum model, and reset/abort sequences.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] length = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, mem_we, busy, cpu_hold, done;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, checksum;

    int total = 0;
    int bad = 0;
    logic [7:0] words [20];

    typedef struct {
        int         len;
        int         vmode;
        int         spur;
        int         exp_writes;
        logic [7:0] exp_sum;
    } vec_t;
    vec_t tbl [7];

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    // vmode: 0 valid every cycle, 1 valid pattern 1,0,0 repeating, 2 random.
    // spur: cycle index at which a stray start (length=1) is driven, -1 none.
    task automatic run_load(input int len, input int vmode, input int spur,
                            input int exp_writes, input logic [7:0] exp_sum);
        int clamp, k, nw, post;
        bit loading, prev_hs, hs, exp_ready;
        clamp = (len > 16) ? 16 : len;
        @(negedge clk);
        start = 1'b1; length = 5'(len); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; length = 5'($urandom);
        loading = (len != 0); k = 0; nw = 0; post = 0; prev_hs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("we_latency", mem_we, prev_hs);
            if (mem_we === 1'b1) begin
                chk("mem_addr", mem_addr, nw);
                chk("mem_wdata", mem_wdata, words[nw < 20 ? nw : 19]);
                nw++;
            end
            exp_ready = loading && (k < clamp);
            chk("in_ready", in_ready, exp_ready);
            chk("busy", busy, loading);
            chk("cpu_hold", cpu_hold, loading);
            chk("done", done, !loading);
            if (!loading) begin
                post++;
                if (post > 4) break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 3 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? words[k < 20 ? k : 19] : 8'($urandom);
            start   = (cyc == spur);
            length  = start ? 5'd1 : 5'($urandom);
            hs = in_valid && exp_ready;
            if (hs) begin
                k++;
                if (k == clamp) loading = 0;
            end
            prev_hs = hs;
            @(negedge clk);
        end
        if (loading) chk("load_timeout", 1, 0);
        in_valid = 1'b0; start = 1'b0;
        chk("write_count", nw, exp_writes);
        chk("checksum", checksum, exp_sum);
        chk("done_final", done, 1);
        $display("load len=%0d vmode=%0d writes=%0d checksum=%02h", len, vmode, nw, checksum);
    endtask

    initial begin
        int clamp, spur;
        logic [7:0] sum;
        for (int i = 0; i < 20; i++)
            words[i] = (i < 16) ? 8'h01 : 8'hFF;
        words[0] = 8'h15; words[1] = 8'h13; words[2] = 8'h20;
        words[3] = 8'h30; words[4] = 8'h00;

        tbl[0] = '{5,  0, -1, 5,  8'h78};
        tbl[1] = '{5,  1, -1, 5,  8'h78};
        tbl[2] = '{0,  0, -1, 0,  8'h00};
        tbl[3] = '{20, 0, -1, 16, 8'h83};
        tbl[4] = '{4,  0,  2, 4,  8'h78};
        tbl[5] = '{1,  2, -1, 1,  8'h15};
        tbl[6] = '{16, 1, -1, 16, 8'h83};

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        $display("reset asserted, outputs idle");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        for (int i = 0; i < 7; i++)
            run_load(tbl[i].len, tbl[i].vmode, tbl[i].spur, tbl[i].exp_writes, tbl[i].exp_sum);

        for (int r = 0; r < 10; r++) begin
            int len;
            len = (r == 0) ? 0 : int'($urandom_range(1, 31));
            for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
            clamp = (len > 16) ? 16 : len;
            sum = 8'h00;
            for (int i = 0; i < clamp; i++) sum = sum + words[i];
            spur = (clamp >= 8) ? int'($urandom_range(0, 3)) : -1;
            run_load(len, 2, spur, clamp, sum);
        end

        // Abort: reset after the 3rd accepted word of an 8-word load.
        @(negedge clk);
        start = 1'b1; length = 5'd8;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = words[j];
            @(negedge clk);
        end
        chk("pre_abort_we", mem_we, 1);
        chk("pre_abort_addr", mem_addr, 2);
        chk("pre_abort_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            chk("post_abort_we", mem_we, 0);
            chk("post_abort_done", done, 0);
            chk("post_abort_hold", cpu_hold, 0);
            chk("post_abort_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        $display("abort: reset after 3 words, writes stopped");

        run_load(2, 0, -1, 2, words[0] + words[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
